// File: rtl/prng_pkg.sv
// Shared definitions for the PRNG arbiter: LFSR width, taps, step function
// and the seed/run state encoding.
package prng_pkg;

    localparam int LFSR_W = 8;
    localparam logic [LFSR_W-1:0] TAP = 8'h1D;

    typedef enum logic {
        S_RUN,
        S_SEED
    } state_t;

    // x^8+x^6+x^5+x^4+1, shifting right with feedback into the MSB
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {^(s & TAP), s[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/prng_rr_arbiter_rr_pick.sv
// Round-robin winner select: first set request above the last winner,
// wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       last,
    output logic             valid,
    output logic [2:0]       idx
);

    always_comb begin
        valid = 1'b0;
        idx   = 3'd0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!valid && req[(int'(last) + i) % N_REQ]) begin
                valid = 1'b1;
                idx   = 3'((int'(last) + i) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/prng_rr_arbiter.sv
// One 8-bit LFSR shared round-robin among N_REQ requesters; each grant
// hands out the current byte and steps the LFSR once.
module prng_rr_arbiter
    import prng_pkg::*;
#(
    parameter int               N_REQ        = 4,
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = 8'hA5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_we,
    input  logic [7:0]       seed,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [7:0]       rdata,
    output logic [2:0]       rid,
    output logic             wrap,
    output logic             busy
);

    state_t             state_q, state_d;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    logic [LFSR_W-1:0]  seed_q, seed_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [2:0]         last_q, last_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [7:0]         rdata_q, rdata_d;
    logic [2:0]         rid_q, rid_d;
    logic               wrap_q, wrap_d;
    logic               pick_valid;
    logic [2:0]         pick_idx;
    logic [LFSR_W-1:0]  lfsr_nxt;
    logic [LFSR_W-1:0]  seed_eff;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (req),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign lfsr_nxt = lfsr_step(lfsr_q);
    assign seed_eff = (seed == '0) ? DEFAULT_SEED : seed;

    always_comb begin
        state_d = S_RUN;
        lfsr_d  = lfsr_q;
        seed_d  = seed_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gnt_d   = '0;
        rdata_d = rdata_q;
        rid_d   = rid_q;
        wrap_d  = 1'b0;
        if (seed_we) begin
            state_d = S_SEED;
            lfsr_d  = seed_eff;
            seed_d  = seed_eff;
            cnt_d   = '0;
        end else if (pick_valid) begin
            gnt_d   = N_REQ'(1) << pick_idx;
            rid_d   = pick_idx;
            rdata_d = lfsr_q;
            lfsr_d  = lfsr_nxt;
            last_d  = pick_idx;
            // Period ends on the step that lands back on the seed
            if (lfsr_nxt == seed_q) begin
                wrap_d = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d  = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            lfsr_q  <= DEFAULT_SEED;
            seed_q  <= DEFAULT_SEED;
            cnt_q   <= '0;
            last_q  <= 3'(N_REQ - 1);
            gnt_q   <= '0;
            rdata_q <= '0;
            rid_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            seed_q  <= seed_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            rdata_q <= rdata_d;
            rid_q   <= rid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign gnt   = gnt_q;
    assign rdata = rdata_q;
    assign rid   = rid_q;
    assign wrap  = wrap_q;
    assign busy  = (state_q == S_SEED);

endmodule

// File: tb/tb_prng_rr_arbiter.sv
// Directed bench for prng_rr_arbiter: LFSR sequence, seeding, wrap,
// round-robin order, zero seed and asynchronous reset.
module tb_prng_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       seed_we;
    logic [7:0] seed;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [7:0] rdata;
    logic [2:0] rid;
    logic       wrap;
    logic       busy;

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] exp_b;
    logic [2:0] exp_w;

    always #5 clk = ~clk;

    prng_rr_arbiter #(.N_REQ(4), .DEFAULT_SEED(8'hA5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .seed_we (seed_we),
        .seed    (seed),
        .req     (req),
        .gnt     (gnt),
        .rdata   (rdata),
        .rid     (rid),
        .wrap    (wrap),
        .busy    (busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] nxt(input logic [7:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[4], s[7:1]};
    endfunction

    initial begin
        rst_n   = 1'b0;
        seed_we = 1'b0;
        seed    = 8'h00;
        req     = 4'b0001;
        #12;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_rid", 32'(rid), 32'h0);
        check("rst_wrap", 32'(wrap), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;

        // 1: lone requester 0 from reset
        tick(); check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_rd0", 32'(rdata), 32'hA5);
        tick(); check("t1_rd1", 32'(rdata), 32'h52);
        tick(); check("t1_rd2", 32'(rdata), 32'hA9);
        tick(); check("t1_rd3", 32'(rdata), 32'h54);
        tick(); check("t1_rd4", 32'(rdata), 32'h2A);
        tick(); check("t1_rd5", 32'(rdata), 32'h95);
        check("t1_gnt5", 32'(gnt), 32'h1);

        // 2: seed 01, full period and wrap
        seed_we = 1'b1; seed = 8'h01;
        tick(); check("t2_seed_gnt", 32'(gnt), 32'h0);
        check("t2_busy", 32'(busy), 32'h1);
        seed_we = 1'b0;
        exp_b = 8'h01;
        for (int k = 1; k <= 256; k++) begin
            tick();
            if (k == 1) check("t2_busy_off", 32'(busy), 32'h0);
            if (k == 2) check("t2_rd80", 32'(rdata), 32'h80);
            if (k == 3) check("t2_rd40", 32'(rdata), 32'h40);
            if (k == 4) check("t2_rd20", 32'(rdata), 32'h20);
            check("t2_gnt", 32'(gnt), 32'h1);
            check("t2_rdata", 32'(rdata), 32'(exp_b));
            check("t2_wrap", 32'(wrap), 32'(k == 255));
            exp_b = nxt(exp_b);
        end

        // 3: all four requesting, last=0 -> 1,2,3,0,1,2,3
        req = 4'b1111;
        exp_w = 3'd0;
        for (int k = 0; k < 7; k++) begin
            tick();
            exp_w = (exp_w + 3'd1) % 3'd4;
            check("t3_gnt", 32'(gnt), 32'(4'b0001 << exp_w));
            check("t3_rid", 32'(rid), 32'(exp_w));
            check("t3_rdata", 32'(rdata), 32'(exp_b));
            check("t3_onehot", 32'($countones(gnt)), 32'd1);
            exp_b = nxt(exp_b);
        end

        // 4: req 1010 with last=3, then requester 2 joins
        req = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t4_gnt", 32'(gnt), (k % 2 == 0) ? 32'h2 : 32'h8);
            check("t4_rdata", 32'(rdata), 32'(exp_b));
            exp_b = nxt(exp_b);
        end
        req = 4'b1110;
        tick(); check("t4_g1", 32'(gnt), 32'h2);
        tick(); check("t4_g2", 32'(gnt), 32'h4);
        tick(); check("t4_g3", 32'(gnt), 32'h8);

        // 5: zero seed while all request; last=3 is kept
        req = 4'b1111; seed_we = 1'b1; seed = 8'h00;
        tick(); check("t5_gnt", 32'(gnt), 32'h0);
        check("t5_busy", 32'(busy), 32'h1);
        seed_we = 1'b0;
        tick(); check("t5_gnt0", 32'(gnt), 32'h1);
        check("t5_rdA5", 32'(rdata), 32'hA5);
        tick(); check("t5_gnt1", 32'(gnt), 32'h2);
        check("t5_rd52", 32'(rdata), 32'h52);

        // 6: asynchronous reset mid-stream
        #2 rst_n = 1'b0;
        #1;
        check("t6_gnt", 32'(gnt), 32'h0);
        check("t6_rdata", 32'(rdata), 32'h0);
        rst_n = 1'b1;
        tick(); check("t6_gnt0", 32'(gnt), 32'h1);
        check("t6_rdA5", 32'(rdata), 32'hA5);
        tick(); check("t6_gnt1", 32'(gnt), 32'h2);

        // idle: no grant, rdata and lfsr hold
        req = 4'b0000;
        tick(); check("idle_gnt", 32'(gnt), 32'h0);
        check("idle_rdata", 32'(rdata), 32'h52);
        req = 4'b0001;
        tick(); check("idle_gnt0", 32'(gnt), 32'h1);
        check("idle_rdA9", 32'(rdata), 32'hA9);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
